// File: rtl/ex_mem_skid_reg_if.sv
// EX->MEM result bus: EX-side push handshake, MEM-side pop handshake, flags and forwarding taps.
// The slave modport is the skid register's view; the master modport is the surrounding pipeline's view.
interface ex_mem_skid_reg_if #(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [REGW-1:0]  in_rd;
  logic             in_regwrite;
  logic             in_setflags;
  logic [3:0]       in_flags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [REGW-1:0]  out_rd;
  logic             out_regwrite;
  logic [3:0]       flags;
  logic             fwd_valid;
  logic [REGW-1:0]  fwd_rd;
  logic [WIDTH-1:0] fwd_result;

  modport master (
    output in_valid, in_result, in_rd, in_regwrite, in_setflags, in_flags, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_regwrite, flags, fwd_valid, fwd_rd, fwd_result
  );

  modport slave (
    input  in_valid, in_result, in_rd, in_regwrite, in_setflags, in_flags, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_regwrite, flags, fwd_valid, fwd_rd, fwd_result
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// Two-entry EX->MEM skid buffer owning the NZCV register and the head forwarding tap.
// Define EX_MEM_FLAG_BYPASS_EN to expose a popped head's flags combinationally in the pop cycle.
module ex_mem_skid_reg #(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  ex_mem_skid_reg_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [REGW-1:0]  rd;
    logic             regwrite;
    logic             setflags;
    logic [3:0]       flags;
  } entry_t;

  state_t     state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic [3:0] flags_q, flags_d;
  entry_t     in_entry;
  logic       push, pop;

  // Ready comes from registered state only, so MEM stalls never reach EX in the same cycle.
  assign bus.in_ready  = ~reset & (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Writes to the zero register (index all-ones) are squashed on entry.
  assign in_entry.result   = bus.in_result;
  assign in_entry.rd       = bus.in_rd;
  assign in_entry.regwrite = bus.in_regwrite & ~(&bus.in_rd);
  assign in_entry.setflags = bus.in_setflags;
  assign in_entry.flags    = bus.in_flags;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    flags_d = flags_q;
    if (bus.flush) begin
      state_d         = EMPTY;
      head_d.regwrite = 1'b0;
      skid_d.regwrite = 1'b0;
    end else begin
      if (pop && head_q.setflags) begin
        flags_d = head_q.flags;
      end
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      flags_q <= flags_d;
    end
  end

  assign bus.out_result   = head_q.result;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_regwrite = head_q.regwrite;
  assign bus.fwd_valid    = bus.out_valid & head_q.regwrite;
  assign bus.fwd_rd       = head_q.rd;
  assign bus.fwd_result   = head_q.result;

`ifdef EX_MEM_FLAG_BYPASS_EN
  assign bus.flags = (pop && head_q.setflags && !bus.flush) ? head_q.flags : flags_q;
`else
  assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: reset, ordering, back-pressure, flags, XZR, flush, async reset.
module tb_ex_mem_skid_reg;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

`ifdef EX_MEM_FLAG_BYPASS_EN
  localparam logic [3:0] FLAGS_IN_POP_CYCLE = 4'b0100;
`else
  localparam logic [3:0] FLAGS_IN_POP_CYCLE = 4'b0000;
`endif

  ex_mem_skid_reg_if #(.WIDTH(64), .REGW(5)) bus ();

  ex_mem_skid_reg #(.WIDTH(64), .REGW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] res, input logic [4:0] rd, input logic rw,
                       input logic sf, input logic [3:0] fl);
    bus.in_valid    = 1'b1;
    bus.in_result   = res;
    bus.in_rd       = rd;
    bus.in_regwrite = rw;
    bus.in_setflags = sf;
    bus.in_flags    = fl;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.flags !== 4'b0000) begin miscompares++; $display("FAIL rst_flags: got %b want 0000", bus.flags); end
    vectors++; if (bus.fwd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_fwd_valid: got %b want 0", bus.fwd_valid); end
    vectors++; if (bus.out_result !== 64'h0) begin miscompares++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    offer(64'h45, 5'd3, 1'b1, 1'b0, 4'b0000);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_result !== 64'h45) begin miscompares++; $display("FAIL single_result: got %h want 45", bus.out_result); end
    vectors++; if (bus.out_rd !== 5'd3) begin miscompares++; $display("FAIL single_rd: got %0d want 3", bus.out_rd); end
    vectors++; if (bus.fwd_valid !== 1'b1) begin miscompares++; $display("FAIL single_fwd_valid: got %b want 1", bus.fwd_valid); end
    vectors++; if (bus.fwd_rd !== 5'd3) begin miscompares++; $display("FAIL single_fwd_rd: got %0d want 3", bus.fwd_rd); end
    vectors++; if (bus.fwd_result !== 64'h45) begin miscompares++; $display("FAIL single_fwd_result: got %h want 45", bus.fwd_result); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    offer(64'h48, 5'd4, 1'b1, 1'b0, 4'b0000);
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one: got %b want 1", bus.in_ready); end
    offer(64'h90, 5'd5, 1'b1, 1'b0, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_result !== 64'h48) begin miscompares++; $display("FAIL b2b_head_first: got %h want 48", bus.out_result); end
    bus.out_ready = 1'b1;
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_result !== 64'h90) begin miscompares++; $display("FAIL b2b_head_second: got %h want 90", bus.out_result); end
    vectors++; if (bus.out_rd !== 5'd5) begin miscompares++; $display("FAIL b2b_rd_second: got %0d want 5", bus.out_rd); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_second: got %b want 1", bus.out_valid); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    offer(64'h11, 5'd6, 1'b1, 1'b0, 4'b0000);
    tick();
    offer(64'h22, 5'd7, 1'b1, 1'b0, 4'b0000);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_result !== 64'h22) begin miscompares++; $display("FAIL pp_replace: got %h want 22", bus.out_result); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL pp_ready: got %b want 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL pp_drain: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flags();
    offer(64'h1, 5'd1, 1'b1, 1'b1, 4'b0100);
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.flags !== 4'b0000) begin miscompares++; $display("FAIL flags_before_pop: got %b want 0000", bus.flags); end
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.flags !== FLAGS_IN_POP_CYCLE) begin miscompares++; $display("FAIL flags_pop_cycle: got %b want %b", bus.flags, FLAGS_IN_POP_CYCLE); end
    tick();
    vectors++; if (bus.flags !== 4'b0100) begin miscompares++; $display("FAIL flags_after_pop: got %b want 0100", bus.flags); end
    bus.out_ready = 1'b0;
    offer(64'h2, 5'd2, 1'b1, 1'b0, 4'b1000);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    vectors++; if (bus.flags !== 4'b0100) begin miscompares++; $display("FAIL flags_nosf_pop: got %b want 0100", bus.flags); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_xzr();
    offer(64'hDEAD, 5'd31, 1'b1, 1'b0, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_regwrite !== 1'b0) begin miscompares++; $display("FAIL xzr_regwrite: got %b want 0", bus.out_regwrite); end
    vectors++; if (bus.fwd_valid !== 1'b0) begin miscompares++; $display("FAIL xzr_fwd_valid: got %b want 0", bus.fwd_valid); end
    vectors++; if (bus.out_result !== 64'hDEAD) begin miscompares++; $display("FAIL xzr_result: got %h want dead", bus.out_result); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL xzr_valid: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    offer(64'hA1, 5'd2, 1'b1, 1'b1, 4'b0011);
    tick();
    offer(64'hB2, 5'd3, 1'b1, 1'b0, 4'b0000);
    tick();
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_setup_full: got %b want 0", bus.in_ready); end
    offer(64'hC3, 5'd4, 1'b1, 1'b0, 4'b0000);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.flags !== 4'b0100) begin miscompares++; $display("FAIL flush_cycle_flags: got %b want 0100", bus.flags); end
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.flags !== 4'b0100) begin miscompares++; $display("FAIL flush_flags: got %b want 0100", bus.flags); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.fwd_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fwd_valid: got %b want 0", bus.fwd_valid); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_ghost: got %b want 0", bus.out_valid); end
    offer(64'h55, 5'd8, 1'b1, 1'b0, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_result !== 64'h55) begin miscompares++; $display("FAIL flush_resume: got %h want 55", bus.out_result); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    offer(64'hE1, 5'd9, 1'b1, 1'b0, 4'b0000);
    tick();
    offer(64'hE2, 5'd10, 1'b1, 1'b0, 4'b0000);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.flags !== 4'b0000) begin miscompares++; $display("FAIL arst_flags: got %b want 0000", bus.flags); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_result !== 64'h0) begin miscompares++; $display("FAIL arst_result: got %h want 0", bus.out_result); end
    bus.out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_release_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_release_valid: got %b want 0", bus.out_valid); end
    offer(64'h77, 5'd11, 1'b1, 1'b0, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_result !== 64'h77) begin miscompares++; $display("FAIL arst_resume: got %h want 77", bus.out_result); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_resume_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_rd       = '0;
    bus.in_regwrite = 1'b0;
    bus.in_setflags = 1'b0;
    bus.in_flags    = 4'b0000;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_push_pop();
    test_flags();
    test_xzr();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Receiving end of the EX-stage ALU result interface; sits between the EX-stage logic units (bitwise AND/OR/XOR, adder, shifter) and the MEM stage.
- 2-entry skid buffer with valid/ready handshake on both sides, so MEM back-pressure never combinationally reaches EX.
- Owns the architectural NZCV flag register and presents head-entry forwarding data to the forwarding unit.

Parameters:
- WIDTH, 64, datapath width of result.
- REGW, 5, destination register index width.

Ports:
- clk, input, 1, single clock, all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, EX presents an entry.
- in_ready, output, 1, buffer can accept an entry.
- in_result, input, WIDTH, ALU result.
- in_rd, input, REGW, destination register.
- in_regwrite, input, 1, entry writes the register file.
- in_setflags, input, 1, entry updates NZCV.
- in_flags, input, 4, {N,Z,C,V} from ALU.
- flush, input, 1, discard all buffered entries.
- out_valid, output, 1, head entry valid to MEM.
- out_ready, input, 1, MEM accepts head.
- out_result, output, WIDTH, head result.
- out_rd, output, REGW, head destination.
- out_regwrite, output, 1, head register-write enable.
- flags, output, 4, committed NZCV.
- fwd_valid, output, 1, head is a forwardable register write.
- fwd_rd, output, REGW, forwarding destination (= out_rd).
- fwd_result, output, WIDTH, forwarding data (= out_result).

Behaviour:
- Reset (async, immediate): state EMPTY, both entries cleared to 0, flags = 4'b0000. in_ready = 0 while reset is asserted and 1 after release. All other outputs are 0.
- States: EMPTY (0 entries), ONE (head only), FULL (head + skid).
- Ready rule: in_ready = ~reset & (state != FULL). It depends on registered state only; it never depends on out_ready.
- push = in_valid & in_ready. pop = out_valid & out_ready. out_valid = (state != EMPTY).
- EMPTY: on push, the entry is loaded into head and the state goes to ONE.
- ONE:
  - push & pop: head is replaced by the new entry; state stays ONE.
  - push only: the entry goes to skid; state goes to FULL.
  - pop only: state goes to EMPTY.
- FULL:
  - pop: skid moves to head; state goes to ONE.
  - No push is possible in FULL.
- Latency: an entry pushed at edge t is visible on out_* after edge t, i.e. one cycle.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- XZR rule: an entry with in_rd == all-ones has regwrite stored as 0. out_regwrite and fwd_valid are 0 for that entry.
- Flags:
  - On pop of a head with setflags = 1, flags take the head's stored {N,Z,C,V} at that edge.
  - Popping a head with setflags = 0 leaves flags unchanged.
- fwd_valid = out_valid & out_regwrite.
- Flush (synchronous): has priority over push and pop in the same cycle. The state goes to EMPTY and both entries' valid and regwrite are cleared. Flags are unchanged, including a pop in the flush cycle.
- in_ready during a flush cycle follows the pre-flush state. Any entry offered in that cycle is discarded.
- Reset mid-operation: everything is cleared immediately; no partial pop is committed.

Optional Feature:
- Macro: EX_MEM_FLAG_BYPASS_EN.
- Defined: flags is combinational. When pop is asserted and the head has setflags = 1, flags shows the head's stored flags in the same cycle, so a dependent B.cond in MEM sees them without waiting a cycle. The register update is otherwise unchanged, and flush suppresses the bypass.
- Undefined: flags is the register output only, and the update is visible the cycle after pop.

Test Plan:
- Reset then single push of result=64'h45, rd=3, regwrite=1, with out_ready=1 -> out_valid=1 one cycle later with out_result=64'h45, out_rd=3, fwd_valid=1, then out_valid=0.
- out_ready=0, push results 0x48 and 0x90 -> in_ready drops to 0 after the 2nd push (FULL). Raise out_ready -> outputs 0x48 then 0x90 in order, and in_ready returns to 1 after the first pop.
- Push with setflags=1, in_flags=4'b0100, then pop -> flags=4'b0100 after the pop edge (same cycle if EX_MEM_FLAG_BYPASS_EN). A following pop with setflags=0, in_flags=4'b1000 -> flags stays 4'b0100.
- Push rd=31, regwrite=1 -> out_regwrite=0 and fwd_valid=0, while out_result is still presented.
- FULL buffer with a setflags head, assert flush together with out_ready=1 and in_valid=1 -> next cycle out_valid=0, flags unchanged, the offered entry is discarded, in_ready=1.
- Assert reset asynchronously mid-stream while FULL -> out_valid, flags, in_ready are 0 immediately. After release, in_ready=1 and the state is EMPTY.
